ppm_rx_sequencer: RTL and testbench

Frame-level controller for the PPM receive path. It sits directly after clock recovery and consumes the per-slot strobe and recovered slot bit. It aligns to the first pulse, checks the preamble, and decodes SLOTS-ary PPM symbols into a valid/ready symbol stream. On every frame end, error or abort it re-arms clock recovery so the recovery block returns to its halt/search state.

---
 rtl/ppm_rx_pkg.sv | 25 ++
 rtl/ppm_rx_sequencer_slot_decoder.sv | 61 ++++++
 rtl/ppm_rx_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ppm_rx_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_rx_pkg.sv
// Shared types and default constants for the PPM receive sequencer.
package ppm_rx_pkg;

   localparam int PPM_SLOTS_DEF        = 4;
   localparam int PPM_PREAMBLE_VAL_DEF = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_SYNC = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_ERASURE   = 3'd1,
      ERR_COLLISION = 3'd2,
      ERR_PREAMBLE  = 3'd3,
      ERR_OVERFLOW  = 3'd4,
      ERR_TIMEOUT   = 3'd5
   } err_e;

endpackage

// File: rtl/ppm_rx_sequencer_slot_decoder.sv
// Per-symbol PPM slot decoder: counts slots, records the high slot and
// flags erasure (no pulse) or collision (two or more pulses) on the last slot.
module ppm_slot_decoder
   import ppm_rx_pkg::*;
#(
   parameter int SLOTS = PPM_SLOTS_DEF,
   localparam int SW = $clog2(SLOTS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick,
   input  logic          data,
   input  logic          clr,
   output logic          sym_done,
   output logic [SW-1:0] sym_idx,
   output logic          zero_err,
   output logic          multi_err
);

   logic [SW-1:0] slot_cnt_q, slot_cnt_d;
   logic [SW-1:0] idx_q, idx_d, idx_upd;
   logic [1:0]    pulse_cnt_q, pulse_cnt_d, pulse_upd;

   always_comb begin
      idx_upd   = idx_q;
      pulse_upd = pulse_cnt_q;
      if (tick && data) begin
         idx_upd = slot_cnt_q;
         if (pulse_cnt_q != 2'd2) pulse_upd = pulse_cnt_q + 2'd1;
      end
      sym_done  = tick && (slot_cnt_q == SW'(SLOTS - 1));
      sym_idx   = idx_upd;
      zero_err  = (pulse_upd == 2'd0);
      multi_err = (pulse_upd == 2'd2);

      // Both an external clear and a completed symbol start the next symbol fresh.
      slot_cnt_d  = slot_cnt_q;
      idx_d       = idx_upd;
      pulse_cnt_d = pulse_upd;
      if (clr || sym_done) begin
         slot_cnt_d  = '0;
         idx_d       = '0;
         pulse_cnt_d = 2'd0;
      end else if (tick) begin
         slot_cnt_d = slot_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_cnt_q  <= '0;
         idx_q       <= '0;
         pulse_cnt_q <= 2'd0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         idx_q       <= idx_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

endmodule

// File: rtl/ppm_rx_sequencer.sv
// Frame-level PPM receive controller: arm, preamble check, symbol stream, rearm.
// Optional watchdog on slot_tick gaps enabled by defining PPM_RX_SEQ_WATCHDOG_EN.
module ppm_rx_sequencer
   import ppm_rx_pkg::*;
#(
   parameter int SLOTS          = PPM_SLOTS_DEF,
   parameter int PREAMBLE_SYMS  = 2,
   parameter int PREAMBLE_VAL   = PPM_PREAMBLE_VAL_DEF,
   parameter int SYMS_PER_FRAME = 16,
   parameter int TIMEOUT_CYC    = 1024,
   localparam int SW = $clog2(SLOTS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          slot_tick,
   input  logic          slot_data,
   input  logic          sym_ready,
   output logic [SW-1:0] sym_data,
   output logic          sym_valid,
   output logic          rec_rearm,
   output logic          frame_start,
   output logic          frame_done,
   output logic [2:0]    err_code,
   output logic          busy
);

   localparam int PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
   localparam int DW = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
   localparam logic [SW-1:0] PRE_SYM = SW'(PREAMBLE_VAL);

   if ((SLOTS < 2) || ((SLOTS & (SLOTS - 1)) != 0) || (TIMEOUT_CYC < 2)) begin : g_bad_cfg
      $error("ppm_rx_sequencer: SLOTS must be a power of two >= 2 and TIMEOUT_CYC >= 2");
   end

   state_e        state_q, state_d;
   err_e          err_code_q, err_code_d, fail_code;
   logic [SW-1:0] sym_data_q, sym_data_d;
   logic          sym_valid_q, sym_valid_d;
   logic          rec_rearm_q, rec_rearm_d;
   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [DW-1:0] dat_cnt_q, dat_cnt_d;
   logic          dec_tick, dec_clr, dec_done, dec_zero, dec_multi, fail, wd_timeout;
   logic [SW-1:0] dec_idx;

   ppm_slot_decoder #(.SLOTS(SLOTS)) u_dec (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (dec_tick),
      .data     (slot_data),
      .clr      (dec_clr),
      .sym_done (dec_done),
      .sym_idx  (dec_idx),
      .zero_err (dec_zero),
      .multi_err(dec_multi)
   );

`ifdef PPM_RX_SEQ_WATCHDOG_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d   = '0;
      wd_timeout = 1'b0;
      if (((state_q == ST_SYNC) || (state_q == ST_DATA)) && !slot_tick) begin
         if (wd_cnt_q == TW'(TIMEOUT_CYC - 1)) wd_timeout = 1'b1;
         else wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wd_cnt_q <= '0;
      else          wd_cnt_q <= wd_cnt_d;
   end
`else
   assign wd_timeout = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      err_code_d    = err_code_q;
      sym_data_d    = sym_data_q;
      sym_valid_d   = sym_valid_q;
      rec_rearm_d   = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      pre_cnt_d     = pre_cnt_q;
      dat_cnt_d     = dat_cnt_q;
      dec_tick      = 1'b0;
      dec_clr       = 1'b1;
      fail          = 1'b0;
      fail_code     = ERR_NONE;

      if (sym_valid_q && sym_ready) sym_valid_d = 1'b0;

      if (!enable) begin
         if (state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            rec_rearm_d  = 1'b1;
            sym_valid_d  = 1'b0;
            frame_done_d = (state_q == ST_DONE);
         end
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               pre_cnt_d = '0;
               dat_cnt_d = '0;
               // The first high tick is slot 0 of the first preamble symbol.
               if (slot_tick && slot_data) begin
                  dec_tick = 1'b1;
                  dec_clr  = 1'b0;
                  state_d  = ST_SYNC;
               end
            end
            ST_SYNC, ST_DATA: begin
               dec_tick = slot_tick;
               dec_clr  = 1'b0;
               if (wd_timeout) begin
                  fail = 1'b1; fail_code = ERR_TIMEOUT;
               end else if (dec_done) begin
                  if (dec_zero) begin
                     fail = 1'b1; fail_code = ERR_ERASURE;
                  end else if (dec_multi) begin
                     fail = 1'b1; fail_code = ERR_COLLISION;
                  end else if (state_q == ST_SYNC) begin
                     if (dec_idx != PRE_SYM) begin
                        fail = 1'b1; fail_code = ERR_PREAMBLE;
                     end else if (pre_cnt_q == PW'(PREAMBLE_SYMS - 1)) begin
                        frame_start_d = 1'b1;
                        err_code_d    = ERR_NONE;
                        state_d       = ST_DATA;
                     end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                     end
                  end else if (sym_valid_q && !sym_ready) begin
                     fail = 1'b1; fail_code = ERR_OVERFLOW;
                  end else begin
                     sym_data_d  = dec_idx;
                     sym_valid_d = 1'b1;
                     if (dat_cnt_q == DW'(SYMS_PER_FRAME - 1)) state_d = ST_DONE;
                     else dat_cnt_d = dat_cnt_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               frame_done_d = 1'b1;
               rec_rearm_d  = 1'b1;
               state_d      = ST_ARM;
            end
            ST_ERR: begin
               rec_rearm_d = 1'b1;
               sym_valid_d = 1'b0;
               state_d     = ST_ARM;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (fail) begin
         err_code_d = fail_code;
         state_d    = ST_ERR;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         err_code_q    <= ERR_NONE;
         sym_data_q    <= '0;
         sym_valid_q   <= 1'b0;
         rec_rearm_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         pre_cnt_q     <= '0;
         dat_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         err_code_q    <= err_code_d;
         sym_data_q    <= sym_data_d;
         sym_valid_q   <= sym_valid_d;
         rec_rearm_q   <= rec_rearm_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         pre_cnt_q     <= pre_cnt_d;
         dat_cnt_q     <= dat_cnt_d;
      end
   end

   assign sym_data    = sym_data_q;
   assign sym_valid   = sym_valid_q;
   assign rec_rearm   = rec_rearm_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign err_code    = err_code_q;
   assign busy        = (state_q == ST_SYNC) || (state_q == ST_DATA);

endmodule

// File: tb/tb_ppm_rx_sequencer.sv
// Scoreboard bench for ppm_rx_sequencer (SLOTS=4, 2 preamble symbols, 16 data symbols).
// Define PPM_RX_SEQ_WATCHDOG_EN for both bench and RTL to exercise the watchdog.
module tb_ppm_rx_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       slot_tick = 1'b0;
   logic       slot_data = 1'b0;
   logic       sym_ready = 1'b1;
   logic [1:0] sym_data;
   logic       sym_valid, rec_rearm, frame_start, frame_done, busy;
   logic [2:0] err_code;

   int n_cmp = 0;
   int n_fail = 0;
   int n_fs = 0, n_fd = 0, n_rr = 0, n_xfer = 0;
   logic [1:0] exp_q[$];

   ppm_rx_sequencer #(
      .SLOTS(4), .PREAMBLE_SYMS(2), .PREAMBLE_VAL(0),
      .SYMS_PER_FRAME(16), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .slot_tick(slot_tick), .slot_data(slot_data), .sym_ready(sym_ready),
      .sym_data(sym_data), .sym_valid(sym_valid), .rec_rearm(rec_rearm),
      .frame_start(frame_start), .frame_done(frame_done),
      .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   // Monitor: pulse widths and symbol transfers, sampled on the falling edge.
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (frame_start) n_fs++;
            if (frame_done)  n_fd++;
            if (rec_rearm)   n_rr++;
            if (sym_valid && sym_ready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sym_xfer: got %0d, required no transfer", sym_data);
               end else begin
                  e = exp_q.pop_front();
                  n_xfer++;
                  if (sym_data !== e) begin
                     n_fail++;
                     $display("FAIL sym_xfer: got %0d, required %0d", sym_data, e);
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic slot(input logic d);
      slot_tick = 1'b1; slot_data = d;
      step(1);
      slot_tick = 1'b0; slot_data = 1'b0;
      step(1);
   endtask

   task automatic send_mask(input logic [3:0] m);
      for (int s = 0; s < 4; s++) slot(m[s]);
   endtask

   task automatic send_sym(input int v);
      logic [3:0] m;
      m = 4'b0001 << v;
      send_mask(m);
   endtask

   task automatic arm_run();
      enable = 1'b0; sym_ready = 1'b1;
      step(3);
      exp_q.delete();
      n_fs = 0; n_fd = 0; n_rr = 0; n_xfer = 0;
      enable = 1'b1;
      step(2);
   endtask

   task automatic test_reset();
      step(3);
      n_cmp++;
      if ({sym_data, err_code} !== 5'd0) begin
         n_fail++; $display("FAIL reset_vec: got %0d/%0d, required 0/0", sym_data, err_code);
      end
      n_cmp++;
      if ({sym_valid, rec_rearm, frame_start, frame_done, busy} !== 5'b0) begin
         n_fail++; $display("FAIL reset_bits: got %b, required 00000",
                            {sym_valid, rec_rearm, frame_start, frame_done, busy});
      end
      reset_n = 1'b1;
      step(2);
   endtask

   task automatic test_clean_frame();
      arm_run();
      send_sym(0); send_sym(0);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(2'(i % 4));
         send_sym(i % 4);
      end
      step(4);
      n_cmp++;
      if (n_xfer !== 16 || exp_q.size() !== 0) begin
         n_fail++; $display("FAIL clean_xfers: got %0d (left %0d), required 16 (left 0)", n_xfer, exp_q.size());
      end
      n_cmp++;
      if ({n_fs, n_fd, n_rr} !== {32'd1, 32'd1, 32'd1}) begin
         n_fail++; $display("FAIL clean_pulses: got fs=%0d fd=%0d rr=%0d, required 1 1 1", n_fs, n_fd, n_rr);
      end
      n_cmp++;
      if (err_code !== 3'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL clean_end: got err=%0d busy=%b, required 0 0", err_code, busy);
      end
   endtask

   task automatic test_preamble_err();
      arm_run();
      send_sym(0); send_sym(2);
      step(3);
      n_cmp++;
      if (err_code !== 3'd3) begin
         n_fail++; $display("FAIL pre_err: got %0d, required 3", err_code);
      end
      n_cmp++;
      if (n_rr !== 1 || n_fs !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL pre_pulses: got rr=%0d fs=%0d busy=%b, required 1 0 0", n_rr, n_fs, busy);
      end
      send_sym(0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL pre_rearmed: got busy=%b, required 1", busy);
      end
   endtask

   task automatic test_symbol_err(input logic [3:0] m, input logic [2:0] code);
      arm_run();
      send_sym(0); send_sym(0);
      exp_q.push_back(2'd1);
      send_sym(1);
      send_mask(m);
      step(3);
      n_cmp++;
      if (err_code !== code) begin
         n_fail++; $display("FAIL sym_err: got %0d, required %0d", err_code, code);
      end
      n_cmp++;
      if (n_xfer !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL sym_err_drop: got xfers=%0d busy=%b, required 1 0", n_xfer, busy);
      end
   endtask

   task automatic test_overflow();
      arm_run();
      sym_ready = 1'b0;
      send_sym(0); send_sym(0);
      send_sym(1);
      n_cmp++;
      if (sym_valid !== 1'b1 || sym_data !== 2'd1) begin
         n_fail++; $display("FAIL ovf_hold: got v=%b d=%0d, required 1 1", sym_valid, sym_data);
      end
      send_sym(2);
      n_cmp++;
      if (err_code !== 3'd4 || sym_data !== 2'd1 || sym_valid !== 1'b0) begin
         n_fail++; $display("FAIL ovf_err: got err=%0d d=%0d v=%b, required 4 1 0", err_code, sym_data, sym_valid);
      end
   endtask

   task automatic test_back_to_back();
      arm_run();
      sym_ready = 1'b0;
      send_sym(0); send_sym(0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd3);
      send_sym(1);
      slot(1'b0); slot(1'b0); slot(1'b0);
      slot_tick = 1'b1; slot_data = 1'b1; sym_ready = 1'b1;
      step(1);
      slot_tick = 1'b0; slot_data = 1'b0;
      step(2);
      n_cmp++;
      if (err_code !== 3'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_state: got err=%0d busy=%b, required 0 1", err_code, busy);
      end
      n_cmp++;
      if (n_xfer !== 2 || exp_q.size() !== 0) begin
         n_fail++; $display("FAIL b2b_xfers: got %0d, required 2", n_xfer);
      end
   endtask

   task automatic test_enable_drop();
      arm_run();
      sym_ready = 1'b0;
      send_sym(0); send_sym(0);
      send_sym(2);
      enable = 1'b0;
      step(1);
      n_cmp++;
      if (busy !== 1'b0 || sym_valid !== 1'b0 || rec_rearm !== 1'b1 || err_code !== 3'd0) begin
         n_fail++; $display("FAIL en_drop: got busy=%b v=%b rr=%b err=%0d, required 0 0 1 0",
                            busy, sym_valid, rec_rearm, err_code);
      end
      step(2);
      n_cmp++;
      if (rec_rearm !== 1'b0 || n_rr !== 1) begin
         n_fail++; $display("FAIL en_drop_pulse: got rr=%b count=%0d, required 0 1", rec_rearm, n_rr);
      end
   endtask

   task automatic test_async_reset();
      arm_run();
      sym_ready = 1'b0;
      send_sym(0); send_sym(0);
      send_sym(3);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({sym_data, err_code, sym_valid, rec_rearm, frame_start, frame_done, busy} !== 10'd0) begin
         n_fail++; $display("FAIL async_reset: got d=%0d err=%0d v=%b busy=%b, required all 0",
                            sym_data, err_code, sym_valid, busy);
      end
      step(2);
      reset_n = 1'b1;
      step(1);
   endtask

   task automatic test_watchdog();
      logic [2:0] e0;
      int cyc;
      arm_run();
      e0 = err_code;
      send_sym(0);
      cyc = 0;
`ifdef PPM_RX_SEQ_WATCHDOG_EN
      while (err_code !== 3'd5 && cyc < 120) begin
         step(1);
         cyc++;
      end
      n_cmp++;
      if (err_code !== 3'd5 || cyc < 60) begin
         n_fail++; $display("FAIL watchdog: got err=%0d after %0d cycles, required 5 after ~64", err_code, cyc);
      end
      step(3);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL watchdog_exit: got busy=%b, required 0", busy);
      end
`else
      step(150);
      n_cmp++;
      if (busy !== 1'b1 || err_code !== e0) begin
         n_fail++; $display("FAIL no_watchdog: got busy=%b err=%0d, required 1 %0d", busy, err_code, e0);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_preamble_err();
      test_symbol_err(4'b0000, 3'd1);
      test_symbol_err(4'b1010, 3'd2);
      test_overflow();
      test_back_to_back();
      test_enable_drop();
      test_async_reset();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
